muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Parametrised RISC-V M-extension execute unit covering all eight funct3 ops:
//  MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU. Multiplies go through a pipeline
//  of MUL_STAGES registers; divides/remainders use an iterative radix-2 restoring
//  divider. Sits in execute beside the ALU. Issue is valid/ready; writeback is a
//  one-cycle valid pulse carrying the destination tag.
// PARAMETERS
//  XLEN        32  operand/result width in bits (>=8, even)
//  MUL_STAGES  2   multiply latency in cycles, accept->wb_valid_o (>=1)
//  TAG_W       5   width of the destination tag (rd index) carried through
// PORTS
//  clk_i          in   1      clock, rising edge
//  reset_i        in   1      asynchronous active-high reset
//  req_valid_i    in   1      issue request valid
//  req_ready_o    out  1      unit can accept this cycle
//  funct3_i       in   3      op: 000 MUL,001 MULH,010 MULHSU,011 MULHU,1xx DIV/DIVU/REM/REMU
//  rs1_value_i    in   XLEN   operand A (dividend)
//  rs2_value_i    in   XLEN   operand B (divisor)
//  tag_i          in   TAG_W  destination tag
//  flush_i        in   1      kill every in-flight op, no writeback
//  wb_valid_o     out  1      result valid, exactly one cycle per completed op
//  wb_value_o     out  XLEN   result
//  wb_tag_o       out  TAG_W  tag of result
//  busy_o         out  1      any op in flight (mul pipe or divider)
// BEHAVIOUR
//  - Reset: all pipe valids 0, divider state IDLE, wb_valid_o=0, wb_value_o=0,
//    wb_tag_o=0, busy_o=0. Reset mid-operation drops the op silently.
//  - Accept = req_valid_i & req_ready_o & ~flush_i.
//  - req_ready_o = (div_state==IDLE) & ~(funct3_i[2] & mul_pipe_nonempty).
//    Back-to-back MULs accepted every cycle; a DIV waits for the mul pipe to
//    drain, so completions can never collide.
//  - MUL path: operands extended to XLEN+1 bits (MULH s*s, MULHSU s*u, MULHU and
//    MUL u*u); signed 2(XLEN+1)-bit product; MUL returns [XLEN-1:0], MULH* return
//    [2XLEN-1:XLEN]. Result + tag appear on wb_* exactly MUL_STAGES cycles after
//    accept. Each stage carries a valid bit; there is no stall.
//  - DIV FSM: IDLE -> SETUP (1 cycle: magnitudes for signed ops, record result
//    signs, detect special cases) -> ITER (XLEN cycles, one quotient bit per
//    cycle) -> FIX (1 cycle: apply signs, drive wb) -> IDLE.
//    Latency is fixed at XLEN+2 cycles from accept to wb_valid_o, special cases
//    included. req_ready_o is low from the cycle after accept until the cycle
//    after FIX.
//  - Signs: quotient negative iff operand signs differ (signed ops only);
//    remainder takes the dividend's sign; rounding is toward zero.
//  - Divide by zero: quotient = all ones, remainder = dividend (both signednesses).
//  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//  - flush_i: clears every mul-pipe valid and forces the divider to IDLE on the
//    next edge; wb_valid_o=0 in that next cycle; a request presented in the
//    same cycle is not accepted. A result on wb_valid_o in the flush cycle itself
//    stands.
//  - wb_value_o/wb_tag_o hold their last value while wb_valid_o=0.
//  - busy_o = any mul valid | div_state!=IDLE.
// TESTING (XLEN=32, MUL_STAGES=2)
//  MUL 0xFFFFFFFF*0xFFFFFFFF -> wb 0x00000001 at +2; MULH same -> 0x00000000;
//    MULHU same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  Three MULs on consecutive cycles, tags 1,2,3 -> three consecutive wb pulses,
//    tags 1,2,3 in order; a DIV issued right after is held off (ready=0) until
//    the pipe is empty.
//  DIV -7/2 -> -3 and REM -7/2 -> -1 at +34; DIVU 7/2 -> 3; ready low during iteration.
//  DIV x/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000,
//    REM same -> 0; latency still 34.
//  flush_i at cycle 10 of a DIV plus one in-flight MUL -> no wb pulses;
//    ready=1 next cycle; a new MUL then completes normally.
//  reset_i asserted asynchronously mid-DIV -> outputs zero immediately;
//    after release ready=1 and no stale wb.

Source files
------------

// File: rtl/muldiv_unit.sv
// RISC-V M-extension unit: pipelined MUL* (MUL_STAGES cycles), iterative DIV*/REM* (XLEN+2 cycles).
// Backpressure: req_ready_o low while the divider is busy, and for a divide while multiplies are in flight.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  rs1_value_i,
  input  logic [XLEN-1:0]  rs2_value_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             wb_valid_o,
  output logic [XLEN-1:0]  wb_value_o,
  output logic [TAG_W-1:0] wb_tag_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_SETUP,
    DIV_ITER,
    DIV_FIX
  } div_state_t;

  div_state_t div_state;

  logic accept;
  logic mul_busy;

  assign req_ready_o = (div_state == DIV_IDLE) & ~(funct3_i[2] & mul_busy);
  assign accept      = req_valid_i & req_ready_o & ~flush_i;
  assign busy_o      = mul_busy | (div_state != DIV_IDLE);

  // Multiply: the low 2*XLEN bits of the sign/zero-extended product are all any op needs.
  logic                   mul0_vld;
  logic [XLEN-1:0]        mul0_res;
  logic                   mul_a_sgn;
  logic                   mul_b_sgn;
  logic signed [2*XLEN-1:0] mul_a_wide;
  logic signed [2*XLEN-1:0] mul_b_wide;
  logic signed [2*XLEN-1:0] mul_prod;

  always_comb begin
    mul_a_sgn  = funct3_i[1] ^ funct3_i[0];
    mul_b_sgn  = ~funct3_i[1] & funct3_i[0];
    mul_a_wide = $signed({{XLEN{mul_a_sgn & rs1_value_i[XLEN-1]}}, rs1_value_i});
    mul_b_wide = $signed({{XLEN{mul_b_sgn & rs2_value_i[XLEN-1]}}, rs2_value_i});
    mul_prod   = mul_a_wide * mul_b_wide;
    mul0_res   = (funct3_i[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    mul0_vld   = accept & ~funct3_i[2];
  end

  logic             last_vld;
  logic [XLEN-1:0]  last_res;
  logic [TAG_W-1:0] last_tag;

  generate
    if (MUL_STAGES == 1) begin : g_no_pipe
      assign last_vld = mul0_vld;
      assign last_res = mul0_res;
      assign last_tag = tag_i;
      assign mul_busy = 1'b0;
    end else begin : g_pipe
      localparam int D = MUL_STAGES - 1;
      logic             stg_vld [D];
      logic [XLEN-1:0]  stg_res [D];
      logic [TAG_W-1:0] stg_tag [D];

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          for (int i = 0; i < D; i++) begin
            stg_vld[i] <= 1'b0;
            stg_res[i] <= '0;
            stg_tag[i] <= '0;
          end
        end else begin
          stg_vld[0] <= mul0_vld;
          stg_res[0] <= mul0_res;
          stg_tag[0] <= tag_i;
          for (int i = 1; i < D; i++) begin
            stg_vld[i] <= stg_vld[i-1] & ~flush_i;
            stg_res[i] <= stg_res[i-1];
            stg_tag[i] <= stg_tag[i-1];
          end
        end
      end

      always_comb begin
        mul_busy = 1'b0;
        for (int i = 0; i < D; i++) mul_busy = mul_busy | stg_vld[i];
      end

      assign last_vld = stg_vld[D-1];
      assign last_res = stg_res[D-1];
      assign last_tag = stg_tag[D-1];
    end
  endgenerate

  // Divider: restoring radix-2 on magnitudes; signs applied on the final step.
  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       div_op;
  logic [TAG_W-1:0] div_tag;
  logic [XLEN-1:0]  div_a;
  logic [XLEN-1:0]  div_quo;
  logic [XLEN-1:0]  div_rem;
  logic [XLEN-1:0]  div_dvs;
  logic             div_q_neg;
  logic             div_r_neg;
  logic             div_zero;

  logic             setup_neg_a;
  logic             setup_neg_b;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    rem_diff;
  logic             step_ok;
  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  quo_next;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;
  logic [XLEN-1:0]  div_result;

  always_comb begin
    setup_neg_a = ~div_op[0] & div_a[XLEN-1];
    setup_neg_b = ~div_op[0] & div_dvs[XLEN-1];
    rem_shift   = {div_rem, div_quo[XLEN-1]};
    rem_diff    = rem_shift - {1'b0, div_dvs};
    step_ok     = ~rem_diff[XLEN];
    rem_next    = step_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_next    = {div_quo[XLEN-2:0], step_ok};
    q_fix       = div_q_neg ? -quo_next : quo_next;
    r_fix       = div_r_neg ? -rem_next : rem_next;
    // MIN / -1 needs no special case: negating the 2^(XLEN-1) magnitude wraps back to MIN.
    if (div_zero) div_result = div_op[1] ? div_a : '1;
    else          div_result = div_op[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_state  <= DIV_IDLE;
      div_cnt    <= '0;
      div_op     <= '0;
      div_tag    <= '0;
      div_a      <= '0;
      div_quo    <= '0;
      div_rem    <= '0;
      div_dvs    <= '0;
      div_q_neg  <= 1'b0;
      div_r_neg  <= 1'b0;
      div_zero   <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_value_o <= '0;
      wb_tag_o   <= '0;
    end else begin
      if (flush_i) begin
        wb_valid_o <= 1'b0;
      end else if (last_vld) begin
        wb_valid_o <= 1'b1;
        wb_value_o <= last_res;
        wb_tag_o   <= last_tag;
      end else if (div_state == DIV_ITER && div_cnt == CNT_LAST) begin
        wb_valid_o <= 1'b1;
        wb_value_o <= div_result;
        wb_tag_o   <= div_tag;
      end else begin
        wb_valid_o <= 1'b0;
      end

      if (flush_i) begin
        div_state <= DIV_IDLE;
      end else begin
        case (div_state)
          DIV_IDLE: begin
            if (accept & funct3_i[2]) begin
              div_op    <= funct3_i[1:0];
              div_tag   <= tag_i;
              div_a     <= rs1_value_i;
              div_dvs   <= rs2_value_i;
              div_state <= DIV_SETUP;
            end
          end
          DIV_SETUP: begin
            div_quo   <= setup_neg_a ? -div_a : div_a;
            div_dvs   <= setup_neg_b ? -div_dvs : div_dvs;
            div_zero  <= (div_dvs == '0);
            div_q_neg <= setup_neg_a ^ setup_neg_b;
            div_r_neg <= setup_neg_a;
            div_rem   <= '0;
            div_cnt   <= '0;
            div_state <= DIV_ITER;
          end
          DIV_ITER: begin
            div_quo <= quo_next;
            div_rem <= rem_next;
            div_cnt <= div_cnt + CNT_W'(1);
            if (div_cnt == CNT_LAST) div_state <= DIV_FIX;
          end
          DIV_FIX:  div_state <= DIV_IDLE;
          default:  div_state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule
